// File: rtl/int_to_float_converter.sv
// 32-bit signed integer to IEEE-754 single-precision converter, round to nearest even.
// Normalizes one bit per clock so no barrel shifter is needed.
//
// state | meaning
// IDLE  | waiting for start; result/inexact held
// NORM  | shifting mag left until its msb is set
// ROUND | round mantissa, publish result, pulse done
module int_to_float_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] mag;
    logic [7:0]  exp_q;
    logic        sign;
    logic        zero;

    logic [31:0] x_abs;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_r;

    // -2^31 negates to itself, which reads correctly as unsigned 0x80000000
    assign x_abs    = x[31] ? (~x + 32'd1) : x;
    assign frac     = mag[30:8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + {23'd0, round_up};
    assign exp_r    = exp_q + {7'd0, frac_sum[23]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (x == 32'd0) ? ROUND : NORM;
                end
            end
            NORM: begin
                if (mag[31]) begin
                    state_next = ROUND;
                end
            end
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag     <= 32'd0;
            exp_q   <= 8'd0;
            sign    <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
            inexact <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= x[31];
                        mag   <= x_abs;
                        exp_q <= 8'd158;
                        zero  <= (x == 32'd0);
                        busy  <= 1'b1;
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                ROUND: begin
                    // a carry out of frac leaves frac_sum[22:0] at zero, as required
                    if (zero) begin
                        result  <= 32'd0;
                        inexact <= 1'b0;
                    end else begin
                        result  <= {sign, exp_r, frac_sum[22:0]};
                        inexact <= guard | sticky;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Scoreboard bench for int_to_float_converter: directed corner cases plus a random sweep
// checked against an arithmetic round-to-nearest-even reference model.
module tb_int_to_float_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        inexact;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [31:0] res;
        logic        inx;
        int          done_edge;
        logic [31:0] xin;
    } exp_t;

    exp_t sb[$];

    int_to_float_converter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x       (x),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .inexact (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // reference: find the msb, keep 24 significant bits, round the remainder to nearest even
    function automatic void ref_model(input logic [31:0] v, output logic [31:0] r,
                                      output logic inx, output int lat);
        logic   sgn;
        longint m, mant, rem, half;
        int     p, e, sh;
        logic [31:0] mant32;
        sgn = v[31];
        m   = sgn ? -longint'($signed(v)) : longint'(v);
        if (m == 0) begin
            r   = 32'd0;
            inx = 1'b0;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (((m >> i) & 1) == 1) p = i;
        e = 127 + p;
        if (p <= 23) begin
            mant = m << (23 - p);
            inx  = 1'b0;
        end else begin
            sh   = p - 23;
            mant = m >> sh;
            rem  = m - (mant << sh);
            half = longint'(1) << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                e    = e + 1;
            end
        end
        mant32 = 32'(mant);
        r   = {sgn, 8'(e), mant32[22:0]};
        lat = 31 - p + 2;
    endfunction

    task automatic convert(input logic [31:0] v, input logic [31:0] r, input logic inx,
                           input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
        end
        start = 1'b1;
        x     = v;
        @(posedge clk);
        #1;
        sb.push_back('{res: r, inx: inx, done_edge: edge_cnt + lat, xin: v});
        start = 1'b0;
        x     = $urandom;
    endtask

    task automatic convert_ref(input logic [31:0] v);
        logic [31:0] r;
        logic        inx;
        int          lat;
        ref_model(v, r, inx, lat);
        convert(v, r, inx, lat);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 at edge %0d with no request pending",
                             edge_cnt);
                end else begin
                    e = sb.pop_front();
                    checks += 3;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result x=%h: got %h, required %h", e.xin, result, e.res);
                    end
                    if (inexact !== e.inx) begin
                        errors++;
                        $display("FAIL inexact x=%h: got %b, required %b", e.xin, inexact, e.inx);
                    end
                    if (edge_cnt != e.done_edge) begin
                        errors++;
                        $display("FAIL latency x=%h: done at edge %0d, required %0d",
                                 e.xin, edge_cnt, e.done_edge);
                    end
                end
            end
            checks++;
            if (busy !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL busy: got %b, required %b at edge %0d", busy, (sb.size() != 0),
                         edge_cnt);
            end
        end
    end

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        start = 1'b0;
        x     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_result", result, 32'd0);
        check_val("reset_inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(32'h0000_0001, 32'h3F80_0000, 1'b0, 33);
        convert(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33);
        convert(32'h8000_0000, 32'hCF00_0000, 1'b0, 2);
        convert(32'h0000_0000, 32'h0000_0000, 1'b0, 1);
        convert(32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3);
        convert(32'd16777217, 32'h4B80_0000, 1'b1, 9);
        convert(32'd16777219, 32'h4B80_0002, 1'b1, 9);

        // start pulsed mid-conversion must be ignored; next start lands in the done cycle
        convert(32'd1000, 32'h447A_0000, 1'b0, 24);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        convert(-32'sd7, 32'hC0E0_0000, 1'b0, 31);
        drain();

        // asynchronous reset three cycles into a conversion
        convert(32'h0000_0001, 32'h3F80_0000, 1'b0, 33);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_result", result, 32'd0);
        check_val("abort_inexact", {31'd0, inexact}, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        convert(32'h0000_0001, 32'h3F80_0000, 1'b0, 33);

        for (int i = 0; i < 3000; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            if ($urandom_range(0, 63) == 0) v = 32'h8000_0000;
            convert_ref(v);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
